sma_signal_engine: RTL and testbench
====================================

Name: sma_signal_engine

Overview:
- Parametrised successor to the fixed six-channel SMA trend/confluence trader.
- Takes N_CH moving-average channels per valid sample and computes a signed fast-minus-slow trend score and rising/falling confluence counts.
- Drives a position state machine (FLAT/LONG/SHORT/COOLDOWN) that emits one-cycle buy/sell pulses.
- Sits between the SMA preprocessor and the order-entry logic.

Parameters:
- DATA_W, 8: unsigned width of each SMA channel.
- N_CH, 6: number of SMA channels; ch0 is the fastest.
- N_PAIRS, 2: number of trend pairs; pair k is ch[k] minus ch[k+N_PAIRS]. Legal range 1 <= N_PAIRS and 2*N_PAIRS <= N_CH.
- THRESH, 77: non-negative trend threshold; strict comparison.
- CONF_TH, 3: minimum number of rising (or falling) channels for confluence.
- COOLDOWN, 4: valid samples to wait after a position exit; 0 means no cooldown.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort to FLAT.
- sma_valid  in  1  sma_data holds a new sample this cycle.
- sma_data  in  N_CH*DATA_W  packed channels, ch0 in the LSBs.
- buy_pulse  out  1  one-cycle buy strobe.
- sell_pulse  out  1  one-cycle sell strobe.
- position  out  2  0=FLAT, 1=LONG, 2=SHORT, 3=COOLDOWN.
- score_out  out  DATA_W+$clog2(N_PAIRS)+2  registered signed trend score.
- trade_count  out  16  count of pulses, saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 and position is FLAT.
  - The prev registers, primed flag, stage-1 valid flag and cooldown counter clear.
- Stage 1 (on sma_valid):
  - prev[i] <= sma_data[i].
  - If the primed flag is 0 (first sample after reset or flush): set primed, raise no s1_valid.
  - Otherwise register rise[i] = cur > prev and fall[i] = cur < prev. Equal values set neither flag.
  - Register score = sum over k of (zext(ch[k]) - zext(ch[k+N_PAIRS])), computed signed at full width with no wrap.
  - Set s1_valid for one cycle. score_out updates here.
- Stage 2 (on s1_valid):
  - up = score > +THRESH; dn = score < -THRESH. up and dn are mutually exclusive.
  - cr = popcount(rise) >= CONF_TH; cf = popcount(fall) >= CONF_TH. Popcount width is $clog2(N_CH+1).
  - The FSM evaluates up/dn/cr/cf and registers the pulses.
- Latency: a pulse asserts exactly 2 clk after the accepting sma_valid edge.
- Throughput: one sample per cycle; back-to-back sma_valid is legal.
- FSM transitions, evaluated only when s1_valid = 1:
  - FLAT: up&cr -> LONG with buy_pulse. dn&cf -> SHORT with sell_pulse. Otherwise stay.
  - LONG: dn&cf -> COOLDOWN with sell_pulse (exit). A buy condition is ignored; no pyramiding.
  - SHORT: up&cr -> COOLDOWN with buy_pulse (exit). A sell condition is ignored.
  - COOLDOWN: the counter loads COOLDOWN on entry. Each s1_valid decrements it; the transition to FLAT occurs on the s1_valid that takes it to 0. No pulses are issued while in COOLDOWN.
  - COOLDOWN == 0: an exit goes directly to FLAT.
- Pulses: buy_pulse and sell_pulse are never high together. Each pulse lasts exactly 1 cycle.
- trade_count increments once per pulse and holds at 16'hFFFF.
- flush:
  - Next edge: position goes to FLAT, the cooldown counter and primed flag clear, and any in-flight s1_valid is discarded with no pulse.
  - trade_count is kept.
  - flush has priority over a simultaneous sma_valid; that sample is dropped and does not prime.
- Reset mid-position: position drops to FLAT asynchronously. The next sample only primes.

Decomposition:
- Package sma_pkg holds:
  - pos_e enum (FLAT, LONG, SHORT, COOLDOWN).
  - Function for the score width.
  - Popcount function.
- One sub-module, sma_trend_stage: stage 1 (prev registers, rise/fall flags, signed score, primed/s1_valid).
- The top holds the FSM, cooldown counter, pulses and trade_count.
- Sub-module parameters: DATA_W, N_CH, N_PAIRS.

Test Plan:
- Buy entry, defaults: prime with all channels 100, then send [200,190,110,105,101,101] (6 rising, score=175). Expect buy_pulse 1 cycle at +2 clk, position=1, trade_count=1, score_out=175.
- Exit and cooldown: from LONG send [50,40,104,103,100,100] (6 falling, score=-117). Expect sell_pulse, position=3. After 4 further valid samples position=0; no pulses occur during COOLDOWN even with a strong signal.
- Threshold boundary: prime all 100, send [140,140,102,101,101,101] (score=77, 6 rising). Expect no pulse, FLAT. The same with ch0=141 (score=78) gives buy_pulse.
- Confluence boundary: prime all 100, send [200,200,100,100,100,100] (score=200, 2 rising). Expect no pulse. With CONF_TH=2 the same stimulus gives buy_pulse.
- Reset and flush: drop rst_n mid-cycle while LONG. Expect position=0 before the next edge and trade_count=0; the next sample only primes. Separately, assert flush together with sma_valid carrying a buy-qualifying sample. Expect no pulse, FLAT, and the next sample only primes.
- Short path and saturation: prime all 200, send [100,100,190,190,199,199]. Expect sell_pulse and position=2. Force the count to 16'hFFFE, then generate 2 more trades; expect trade_count to hold at 16'hFFFF.

Source files
------------

// File: rtl/sma_pkg.sv
// Shared types and helpers for the SMA signal engine.
//   pos_e    : position encoding driven on the position output
//   score_w  : width of the signed trend score for a given channel width / pair count
//   popcount : number of set bits in a flag vector (up to 64 channels)
package sma_pkg;

  typedef enum logic [1:0] {
    POS_FLAT     = 2'd0,
    POS_LONG     = 2'd1,
    POS_SHORT    = 2'd2,
    POS_COOLDOWN = 2'd3
  } pos_e;

  // One bit for sign, one for the difference of two unsigned values,
  // plus growth for summing n_pairs differences.
  function automatic int score_w(input int data_w, input int n_pairs);
    return data_w + $clog2(n_pairs) + 2;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sma_signal_engine_if.sv
// Sample input / trade output bundle of the SMA signal engine.
//   flush, sma_valid, sma_data        : upstream (SMA preprocessor) side
//   buy_pulse, sell_pulse, position,
//   score_out, trade_count            : downstream (order entry) side
// master = driver of samples, slave = the engine.
interface sma_signal_engine_if #(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 6,
  parameter int N_PAIRS = 2
);
  import sma_pkg::*;

  localparam int SCORE_W = score_w(DATA_W, N_PAIRS);

  logic                      flush;
  logic                      sma_valid;
  logic [N_CH*DATA_W-1:0]    sma_data;
  logic                      buy_pulse;
  logic                      sell_pulse;
  logic [1:0]                position;
  logic signed [SCORE_W-1:0] score_out;
  logic [15:0]               trade_count;

  modport master (
    output flush, sma_valid, sma_data,
    input  buy_pulse, sell_pulse, position, score_out, trade_count
  );

  modport slave (
    input  flush, sma_valid, sma_data,
    output buy_pulse, sell_pulse, position, score_out, trade_count
  );

endinterface

// File: rtl/sma_trend_stage.sv
// First pipeline stage: remembers the previous sample, flags per-channel
// rise/fall and computes the signed fast-minus-slow trend score.
//   clk, rst_n      : clock, async active-low reset
//   flush           : clears primed/s1_valid, drops the current sample
//   sma_valid/data  : incoming packed channels, ch0 in the LSBs
//   rise, fall      : per-channel direction flags of the last primed sample
//   score           : registered signed trend score
//   s1_valid        : one-cycle strobe, rise/fall/score are fresh
module sma_trend_stage
  import sma_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_CH    = 6,
  parameter int N_PAIRS = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush,
  input  logic                                         sma_valid,
  input  logic [N_CH*DATA_W-1:0]                       sma_data,
  output logic [N_CH-1:0]                              rise,
  output logic [N_CH-1:0]                              fall,
  output logic signed [score_w(DATA_W, N_PAIRS)-1:0]   score,
  output logic                                         s1_valid
);

  localparam int SCORE_W = score_w(DATA_W, N_PAIRS);

  logic [N_CH*DATA_W-1:0]    prev_data;
  logic                      primed;
  logic [N_CH-1:0]           rise_c;
  logic [N_CH-1:0]           fall_c;
  logic signed [SCORE_W-1:0] score_c;

  always_comb begin
    rise_c = '0;
    fall_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise_c[i] = sma_data[i*DATA_W +: DATA_W] > prev_data[i*DATA_W +: DATA_W];
      fall_c[i] = sma_data[i*DATA_W +: DATA_W] < prev_data[i*DATA_W +: DATA_W];
    end
  end

  // Channels are zero-extended before subtracting so the sum never wraps.
  always_comb begin
    score_c = '0;
    for (int k = 0; k < N_PAIRS; k++) begin
      score_c = score_c
              + $signed(SCORE_W'(sma_data[k*DATA_W +: DATA_W]))
              - $signed(SCORE_W'(sma_data[(k+N_PAIRS)*DATA_W +: DATA_W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_data <= '0;
      primed    <= 1'b0;
      rise      <= '0;
      fall      <= '0;
      score     <= '0;
      s1_valid  <= 1'b0;
    end else if (flush) begin
      primed    <= 1'b0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= 1'b0;
      if (sma_valid) begin
        prev_data <= sma_data;
        if (!primed) begin
          primed <= 1'b1;
        end else begin
          rise     <= rise_c;
          fall     <= fall_c;
          score    <= score_c;
          s1_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sma_signal_engine.sv
// SMA trend/confluence signal engine: stage-1 trend extraction followed by
// a position state machine issuing one-cycle buy/sell strobes.
//   clk, rst_n : clock, async active-low reset
//   bus        : sample input and trade outputs (slave side)
//
// state        | meaning
// -------------+-------------------------------------------------------
// POS_FLAT     | no position, entry on up&cr (buy) or dn&cf (sell)
// POS_LONG     | long, exits with sell on dn&cf
// POS_SHORT    | short, exits with buy on up&cr
// POS_COOLDOWN | post-exit hold, counts scored samples down to FLAT
module sma_signal_engine
  import sma_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int N_CH     = 6,
  parameter int N_PAIRS  = 2,
  parameter int THRESH   = 77,
  parameter int CONF_TH  = 3,
  parameter int COOLDOWN = 4
) (
  input logic                clk,
  input logic                rst_n,
  sma_signal_engine_if.slave bus
);

  localparam int   SCORE_W = score_w(DATA_W, N_PAIRS);
  localparam int   CNT_W   = $clog2(N_CH + 1);
  localparam int   CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [SCORE_W-1:0] THRESH_P = SCORE_W'(THRESH);
  localparam logic signed [SCORE_W-1:0] THRESH_N = -SCORE_W'(THRESH);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam pos_e EXIT_STATE = (COOLDOWN == 0) ? POS_FLAT : POS_COOLDOWN;

  logic [N_CH-1:0]           rise;
  logic [N_CH-1:0]           fall;
  logic signed [SCORE_W-1:0] score;
  logic                      s1_valid;

  sma_trend_stage #(
    .DATA_W  (DATA_W),
    .N_CH    (N_CH),
    .N_PAIRS (N_PAIRS)
  ) u_trend (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .sma_valid (bus.sma_valid),
    .sma_data  (bus.sma_data),
    .rise      (rise),
    .fall      (fall),
    .score     (score),
    .s1_valid  (s1_valid)
  );

  logic [CNT_W-1:0] n_rise;
  logic [CNT_W-1:0] n_fall;
  logic             up, dn, cr, cf;

  assign n_rise = CNT_W'(popcount(64'(rise)));
  assign n_fall = CNT_W'(popcount(64'(fall)));
  assign up     = score > THRESH_P;
  assign dn     = score < THRESH_N;
  assign cr     = n_rise >= CNT_W'(CONF_TH);
  assign cf     = n_fall >= CNT_W'(CONF_TH);

  pos_e            state, state_nxt;
  logic [CD_W-1:0] cd_cnt, cd_nxt;
  logic            buy_q, sell_q, buy_nxt, sell_nxt;
  logic [15:0]     trade_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= POS_FLAT;
      cd_cnt  <= '0;
      buy_q   <= 1'b0;
      sell_q  <= 1'b0;
      trade_q <= '0;
    end else if (bus.flush) begin
      state   <= POS_FLAT;
      cd_cnt  <= '0;
      buy_q   <= 1'b0;
      sell_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cd_cnt  <= cd_nxt;
      buy_q   <= buy_nxt;
      sell_q  <= sell_nxt;
      if ((buy_nxt || sell_nxt) && (trade_q != 16'hFFFF)) begin
        trade_q <= trade_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (s1_valid) begin
      case (state)
        POS_FLAT: begin
          if (up && cr)      state_nxt = POS_LONG;
          else if (dn && cf) state_nxt = POS_SHORT;
        end
        POS_LONG:     if (dn && cf) state_nxt = EXIT_STATE;
        POS_SHORT:    if (up && cr) state_nxt = EXIT_STATE;
        // Terminal count: this scored sample takes the counter to zero.
        POS_COOLDOWN: if (cd_cnt <= CD_W'(1)) state_nxt = POS_FLAT;
        default:      state_nxt = POS_FLAT;
      endcase
    end
  end

  always_comb begin
    buy_nxt  = 1'b0;
    sell_nxt = 1'b0;
    cd_nxt   = cd_cnt;
    if (s1_valid) begin
      case (state)
        POS_FLAT: begin
          if (up && cr)      buy_nxt  = 1'b1;
          else if (dn && cf) sell_nxt = 1'b1;
        end
        POS_LONG: begin
          if (dn && cf) begin
            sell_nxt = 1'b1;
            cd_nxt   = CD_LOAD;
          end
        end
        POS_SHORT: begin
          if (up && cr) begin
            buy_nxt = 1'b1;
            cd_nxt  = CD_LOAD;
          end
        end
        POS_COOLDOWN: if (cd_cnt != '0) cd_nxt = cd_cnt - CD_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.buy_pulse   = buy_q;
  assign bus.sell_pulse  = sell_q;
  assign bus.position    = state;
  assign bus.score_out   = score;
  assign bus.trade_count = trade_q;

endmodule

// File: tb/tb_sma_signal_engine.sv
module tb_sma_signal_engine;
  import sma_pkg::*;

  localparam int DATA_W  = 8;
  localparam int N_CH    = 6;
  localparam int N_PAIRS = 2;
  localparam int THRESH  = 77;

  typedef int samp_t [6];

  typedef struct {
    bit is_buy;
    int pos;
    int tc;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sma_signal_engine_if #(.DATA_W(DATA_W), .N_CH(N_CH), .N_PAIRS(N_PAIRS)) bus_a ();
  sma_signal_engine_if #(.DATA_W(DATA_W), .N_CH(N_CH), .N_PAIRS(N_PAIRS)) bus_b ();

  sma_signal_engine #(.DATA_W(DATA_W), .N_CH(N_CH), .N_PAIRS(N_PAIRS), .THRESH(THRESH),
                      .CONF_TH(3), .COOLDOWN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  sma_signal_engine #(.DATA_W(DATA_W), .N_CH(N_CH), .N_PAIRS(N_PAIRS), .THRESH(THRESH),
                      .CONF_TH(2), .COOLDOWN(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Reference model: one trading desk per DUT instance.
  int  m_conf [2] = '{3, 2};
  int  m_cdlen[2] = '{4, 0};
  int  m_prev [2][6];
  bit  m_primed[2];
  int  m_pos  [2];
  int  m_cd   [2];
  int  m_tc   [2];
  int  m_score[2];
  bit  m_pend [2];
  int  m_pscore[2], m_pnr[2], m_pnf[2];
  ev_t evq[2][$];

  samp_t S_ZERO = '{0, 0, 0, 0, 0, 0};
  samp_t S_100  = '{100, 100, 100, 100, 100, 100};
  samp_t S_200  = '{200, 200, 200, 200, 200, 200};
  samp_t S_BUY  = '{200, 190, 110, 105, 101, 101};
  samp_t S_SELL = '{50, 40, 104, 103, 100, 100};
  samp_t S_TH77 = '{140, 140, 102, 101, 101, 101};
  samp_t S_TH78 = '{141, 140, 102, 101, 101, 101};
  samp_t S_CONF = '{200, 200, 100, 100, 100, 100};
  samp_t S_SHRT = '{100, 100, 190, 190, 199, 199};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] pk(input samp_t s);
    logic [47:0] r;
    for (int c = 0; c < 6; c++) r[c*8 +: 8] = 8'(s[c]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 6; c++) m_prev[i][c] = 0;
      m_primed[i] = 0; m_pos[i] = 0; m_cd[i] = 0; m_tc[i] = 0;
      m_score[i] = 0; m_pend[i] = 0;
      evq[i].delete();
    end
  endtask

  // Trading decision for a scored sample; the pulse is visible in the next cycle.
  task automatic apply(input int i);
    bit up, dn, cr, cf, pulse, buy, exit_pos;
    ev_t e;
    up = m_pscore[i] > THRESH;
    dn = m_pscore[i] < -THRESH;
    cr = m_pnr[i] >= m_conf[i];
    cf = m_pnf[i] >= m_conf[i];
    pulse = 0; buy = 0; exit_pos = 0;
    case (m_pos[i])
      0: if (up && cr) begin m_pos[i] = 1; pulse = 1; buy = 1; end
         else if (dn && cf) begin m_pos[i] = 2; pulse = 1; end
      1: if (dn && cf) begin exit_pos = 1; pulse = 1; end
      2: if (up && cr) begin exit_pos = 1; pulse = 1; buy = 1; end
      default: begin
        m_cd[i]--;
        if (m_cd[i] == 0) m_pos[i] = 0;
      end
    endcase
    if (exit_pos) begin
      if (m_cdlen[i] == 0) m_pos[i] = 0;
      else begin m_pos[i] = 3; m_cd[i] = m_cdlen[i]; end
    end
    if (pulse) begin
      if (m_tc[i] < 65535) m_tc[i]++;
      e.is_buy = buy; e.pos = m_pos[i]; e.tc = m_tc[i]; e.cyc = cyc + 1;
      evq[i].push_back(e);
    end
  endtask

  task automatic model_step(input int i, input bit f, input bit v, input samp_t s);
    int nr, nf, sc;
    if (m_pend[i] && !f) apply(i);
    m_pend[i] = 0;
    if (f) begin
      m_pos[i] = 0; m_cd[i] = 0; m_primed[i] = 0;
    end else if (v) begin
      if (m_primed[i]) begin
        nr = 0; nf = 0; sc = 0;
        for (int c = 0; c < 6; c++) begin
          if (s[c] > m_prev[i][c]) nr++;
          if (s[c] < m_prev[i][c]) nf++;
        end
        for (int k = 0; k < N_PAIRS; k++) sc += s[k] - s[k + N_PAIRS];
        m_pend[i] = 1; m_pscore[i] = sc; m_pnr[i] = nr; m_pnf[i] = nf;
        m_score[i] = sc;
      end else begin
        m_primed[i] = 1;
      end
      for (int c = 0; c < 6; c++) m_prev[i][c] = s[c];
    end
  endtask

  // Called at a falling edge; inputs are sampled by the following rising edge.
  task automatic tick2(input bit f0, input bit v0, input samp_t s0,
                       input bit f1, input bit v1, input samp_t s1);
    model_step(0, f0, v0, s0);
    model_step(1, f1, v1, s1);
    bus_a.flush = f0; bus_a.sma_valid = v0; bus_a.sma_data = pk(s0);
    bus_b.flush = f1; bus_b.sma_valid = v1; bus_b.sma_data = pk(s1);
    @(negedge clk);
  endtask

  task automatic send(input int id, input samp_t s);
    if (id == 0) tick2(0, 1, s, 0, 0, S_ZERO);
    else         tick2(0, 0, S_ZERO, 0, 1, s);
  endtask

  task automatic flush_one(input int id);
    if (id == 0) tick2(1, 0, S_ZERO, 0, 0, S_ZERO);
    else         tick2(0, 0, S_ZERO, 1, 0, S_ZERO);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick2(0, 0, S_ZERO, 0, 0, S_ZERO);
  endtask

  task automatic check_state(input int id, input string tag);
    int p, t, sc;
    if (id == 0) begin p = bus_a.position; t = bus_a.trade_count; sc = bus_a.score_out; end
    else         begin p = bus_b.position; t = bus_b.trade_count; sc = bus_b.score_out; end
    chk({tag, "_position"}, p, m_pos[id]);
    chk({tag, "_trade_count"}, t, m_tc[id]);
    chk({tag, "_score_out"}, sc, m_score[id]);
  endtask

  function automatic int pos_of(input int id);
    return (id == 0) ? int'(bus_a.position) : int'(bus_b.position);
  endfunction

  function automatic int tc_of(input int id);
    return (id == 0) ? int'(bus_a.trade_count) : int'(bus_b.trade_count);
  endfunction

  // Monitor: every pulse (or expected pulse) is matched against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic b, s, seen, due;
      ev_t  e;
      b = (i == 0) ? bus_a.buy_pulse  : bus_b.buy_pulse;
      s = (i == 0) ? bus_a.sell_pulse : bus_b.sell_pulse;
      seen = b | s;
      due  = (evq[i].size() != 0) && (evq[i][0].cyc <= cyc);
      if (seen || due) begin
        chk($sformatf("pulse_present_dut%0d_cyc%0d", i, cyc), seen, due);
        if (seen) chk($sformatf("pulse_exclusive_dut%0d", i), b & s, 0);
        if (due) begin
          e = evq[i].pop_front();
          if (seen) begin
            chk($sformatf("pulse_cycle_dut%0d", i), cyc, e.cyc);
            chk($sformatf("pulse_is_buy_dut%0d", i), b, e.is_buy);
            chk($sformatf("pulse_position_dut%0d", i), pos_of(i), e.pos);
            chk($sformatf("pulse_trade_count_dut%0d", i), tc_of(i), e.tc);
          end
        end
      end
    end
  end

  initial begin
    samp_t r0, r1;
    bit f0, f1, v0, v1;

    model_reset();
    bus_a.flush = 0; bus_a.sma_valid = 0; bus_a.sma_data = '0;
    bus_b.flush = 0; bus_b.sma_valid = 0; bus_b.sma_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_state(0, "reset_a");
    check_state(1, "reset_b");

    // Buy entry
    send(0, S_100);
    send(0, S_BUY);
    idle(3);
    chk("buy_position", bus_a.position, 1);
    chk("buy_trade_count", bus_a.trade_count, 1);
    chk("buy_score_out", bus_a.score_out, 175);
    check_state(0, "buy");

    // Exit into cooldown; strong signals during cooldown must not trade
    send(0, S_SELL);
    idle(3);
    chk("exit_position", bus_a.position, 3);
    chk("exit_score_out", bus_a.score_out, -117);
    send(0, S_BUY); send(0, S_SELL); send(0, S_BUY);
    idle(3);
    chk("cooldown_hold_position", bus_a.position, 3);
    send(0, S_SELL);
    idle(3);
    chk("cooldown_done_position", bus_a.position, 0);
    chk("cooldown_trade_count", bus_a.trade_count, 2);
    check_state(0, "cooldown");

    // Threshold boundary: 77 is not enough, 78 is
    flush_one(0); send(0, S_100); send(0, S_TH77); idle(3);
    chk("thresh77_position", bus_a.position, 0);
    chk("thresh77_score_out", bus_a.score_out, 77);
    flush_one(0); send(0, S_100); send(0, S_TH78); idle(3);
    chk("thresh78_position", bus_a.position, 1);
    check_state(0, "thresh78");
    flush_one(0); idle(2);
    chk("flush_keeps_count", bus_a.trade_count, 3);

    // Confluence boundary: 2 rising channels, CONF_TH 3 vs 2
    send(0, S_100); send(1, S_100);
    send(0, S_CONF); send(1, S_CONF);
    idle(3);
    chk("conf3_position", bus_a.position, 0);
    chk("conf2_position", bus_b.position, 1);
    check_state(0, "conf_a");
    check_state(1, "conf_b");

    // Asynchronous reset while long
    flush_one(0); send(0, S_100); send(0, S_BUY); idle(3);
    chk("pre_reset_position", bus_a.position, 1);
    #2; rst_n = 1'b0; #1;
    chk("reset_async_position", bus_a.position, 0);
    chk("reset_async_trade_count", bus_a.trade_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, S_100); send(0, S_BUY); idle(3);
    chk("post_reset_buy_position", bus_a.position, 1);
    check_state(0, "post_reset");

    // flush together with a buy-qualifying sample
    flush_one(0); send(0, S_100);
    tick2(1, 1, S_BUY, 0, 0, S_ZERO);
    idle(3);
    chk("flush_valid_position", bus_a.position, 0);
    send(0, S_BUY); idle(3);
    chk("flush_next_primes_only", bus_a.position, 0);
    check_state(0, "flush");

    // Short entry
    flush_one(0); send(0, S_200); send(0, S_SHRT); idle(3);
    chk("short_position", bus_a.position, 2);
    chk("short_score_out", bus_a.score_out, -180);
    check_state(0, "short");

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 6; c++) begin
        r0[c] = $urandom_range(0, 255);
        r1[c] = $urandom_range(0, 255);
      end
      f0 = $urandom_range(0, 99) < 2;
      f1 = $urandom_range(0, 99) < 2;
      v0 = $urandom_range(0, 99) < 70;
      v1 = $urandom_range(0, 99) < 70;
      tick2(f0, v0, r0, f1, v1, r1);
    end
    idle(3);
    check_state(0, "random_a");
    check_state(1, "random_b");

    // Drive instance b to trade on every sample until the counter saturates
    flush_one(1);
    send(1, S_SELL);
    while (m_tc[1] < 65535) begin
      send(1, S_BUY);
      send(1, S_SELL);
    end
    send(1, S_BUY);
    send(1, S_SELL);
    idle(3);
    chk("saturated_trade_count", bus_b.trade_count, 65535);
    check_state(1, "saturate");

    idle(2);
    chk("scoreboard_drained_a", evq[0].size(), 0);
    chk("scoreboard_drained_b", evq[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
